// File: rtl/hwt_output_monitor.sv
// Runtime tamper checker for the non-HWT stage: recomputes Y = D & ((A & B) | C) in a
// two-stage pipeline, counts samples/mismatches, sticky alarm. Optional macro: HWT_MON_LOG_EN.
module hwt_output_monitor #(
   parameter int CNT_W  = 8,
   parameter int THRESH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             smp_vld,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   input  logic             y,
   output logic             alarm,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] mm_cnt,
   output logic [CNT_W-1:0] smp_cnt,
   output logic             smp_sat
`ifdef HWT_MON_LOG_EN
   ,
   output logic [3:0]       first_vec
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ARMED = 2'b01,
      ST_ALARM = 2'b10
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
   logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
   logic             v1_q, v1_d;
   logic             a1_q, a1_d, b1_q, b1_d, c1_q, c1_d, d1_q, d1_d, y1_q, y1_d;
   logic             exp_s, mm_s, cnt_s;
   logic [CNT_W-1:0] mm_inc_s;

   always_comb begin
      // stage 1 capture; clr drops whatever is in flight
      v1_d = clr ? 1'b0 : smp_vld;
      a1_d = a;
      b1_d = b;
      c1_d = c;
      d1_d = d;
      y1_d = y;

      // stage 2 golden compare and qualification
      exp_s    = d1_q & ((a1_q & b1_q) | c1_q);
      mm_s     = v1_q & (y1_q != exp_s);
      cnt_s    = v1_q & (state_q == ST_ARMED);
      mm_inc_s = sat_inc(mm_cnt_q);

      state_d   = state_q;
      mm_cnt_d  = mm_cnt_q;
      smp_cnt_d = smp_cnt_q;

      if (clr) begin
         state_d   = ST_IDLE;
         mm_cnt_d  = '0;
         smp_cnt_d = '0;
      end else begin
         if (cnt_s) begin
            smp_cnt_d = sat_inc(smp_cnt_q);
            if (mm_s) mm_cnt_d = mm_inc_s;
         end
         case (state_q)
            ST_IDLE:  if (en) state_d = ST_ARMED;
            ST_ARMED: begin
               // a threshold-reaching mismatch wins over a simultaneous disarm
               if (cnt_s && mm_s && (mm_inc_s >= THRESH_C)) state_d = ST_ALARM;
               else if (!en)                                 state_d = ST_IDLE;
            end
            ST_ALARM: state_d = ST_ALARM;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         mm_cnt_q  <= '0;
         smp_cnt_q <= '0;
         v1_q      <= 1'b0;
         a1_q      <= 1'b0;
         b1_q      <= 1'b0;
         c1_q      <= 1'b0;
         d1_q      <= 1'b0;
         y1_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         mm_cnt_q  <= mm_cnt_d;
         smp_cnt_q <= smp_cnt_d;
         v1_q      <= v1_d;
         a1_q      <= a1_d;
         b1_q      <= b1_d;
         c1_q      <= c1_d;
         d1_q      <= d1_d;
         y1_q      <= y1_d;
      end
   end

`ifdef HWT_MON_LOG_EN
   logic [3:0] first_vec_q, first_vec_d;

   always_comb begin
      first_vec_d = first_vec_q;
      if (clr) first_vec_d = 4'b0000;
      else if (cnt_s && mm_s && (mm_cnt_q == '0)) first_vec_d = {a1_q, b1_q, c1_q, d1_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) first_vec_q <= 4'b0000;
      else        first_vec_q <= first_vec_d;
   end

   assign first_vec = first_vec_q;
`endif

   assign state   = state_q;
   assign alarm   = (state_q == ST_ALARM);
   assign mm_cnt  = mm_cnt_q;
   assign smp_cnt = smp_cnt_q;
   assign smp_sat = (smp_cnt_q == CNT_MAX);

endmodule

// File: tb/tb_hwt_output_monitor.sv
// Directed bench for hwt_output_monitor: default instance (CNT_W=8, THRESH=1) plus a
// CNT_W=4 / THRESH=15 instance for saturation.
module tb_hwt_output_monitor;

   logic clk = 1'b0;
   logic rst_n, en, clr, en2, clr2, smp_vld, a, b, c, d, y;

   logic       alarm1, smp_sat1;
   logic [1:0] state1;
   logic [7:0] mm_cnt1, smp_cnt1;
   logic       alarm2, smp_sat2;
   logic [1:0] state2;
   logic [3:0] mm_cnt2, smp_cnt2;
`ifdef HWT_MON_LOG_EN
   logic [3:0] first_vec1, first_vec2;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   hwt_output_monitor #(.CNT_W(8), .THRESH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .smp_vld(smp_vld),
      .a(a), .b(b), .c(c), .d(d), .y(y),
      .alarm(alarm1), .state(state1), .mm_cnt(mm_cnt1), .smp_cnt(smp_cnt1),
      .smp_sat(smp_sat1)
`ifdef HWT_MON_LOG_EN
      , .first_vec(first_vec1)
`endif
   );

   hwt_output_monitor #(.CNT_W(4), .THRESH(15)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en2), .clr(clr2), .smp_vld(smp_vld),
      .a(a), .b(b), .c(c), .d(d), .y(y),
      .alarm(alarm2), .state(state2), .mm_cnt(mm_cnt2), .smp_cnt(smp_cnt2),
      .smp_sat(smp_sat2)
`ifdef HWT_MON_LOG_EN
      , .first_vec(first_vec2)
`endif
   );

   function automatic logic gold(input logic [3:0] v);
      return v[0] & ((v[3] & v[2]) | v[1]);
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      tests++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] v, input logic yy);
      {a, b, c, d} = v;
      y       = yy;
      smp_vld = 1'b1;
      tick();
   endtask

   task automatic send_ok(input logic [3:0] v);
      send(v, gold(v));
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; en2 = 1'b0; clr2 = 1'b0;
      smp_vld = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0; y = 1'b0;
      repeat (3) tick();
      chk("rst_state", state1, 2'b00);
      chk("rst_alarm", alarm1, 1'b0);
      chk("rst_mm", mm_cnt1, 8'd0);
      chk("rst_smp", smp_cnt1, 8'd0);
      chk("rst_sat2", smp_sat2, 1'b0);
`ifdef HWT_MON_LOG_EN
      chk("rst_fv", first_vec1, 4'b0000);
`endif
      rst_n = 1'b1;

      // arm and clean sweep of all 16 input combinations
      en = 1'b1;
      tick();
      chk("arm_state", state1, 2'b01);
      chk("idle2_state", state2, 2'b00);
      for (int i = 0; i < 16; i++) send_ok(4'(i));
      smp_vld = 1'b0;
      tick();
      chk("sweep_smp", smp_cnt1, 8'd16);
      chk("sweep_mm", mm_cnt1, 8'd0);
      chk("sweep_alarm", alarm1, 1'b0);
      chk("sweep_state", state1, 2'b01);

      // asynchronous reset mid-stream, then pipeline latency after release
      send_ok(4'h3);
      #2 rst_n = 1'b0;
      #1;
      chk("async_state", state1, 2'b00);
      chk("async_smp", smp_cnt1, 8'd0);
      chk("async_alarm", alarm1, 1'b0);
      #1 rst_n = 1'b1;
      tick();
      chk("lat1_smp", smp_cnt1, 8'd0);
      chk("lat1_state", state1, 2'b01);
      tick();
      chk("lat2_smp", smp_cnt1, 8'd1);

      // clr together with en lands in IDLE, arming one edge later
      smp_vld = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clren_state", state1, 2'b00);
      chk("clren_smp", smp_cnt1, 8'd0);
      tick();
      chk("rearm_state", state1, 2'b01);

      // single fault with THRESH=1
      send(4'b1101, 1'b0);
      send_ok(4'h0);
      chk("fault_mm", mm_cnt1, 8'd1);
      chk("fault_alarm", alarm1, 1'b1);
      chk("fault_state", state1, 2'b10);
      chk("fault_smp", smp_cnt1, 8'd1);
      send(4'h3, 1'b0);
      send(4'h0, 1'b1);
      smp_vld = 1'b0;
      tick();
      tick();
      chk("frozen_smp", smp_cnt1, 8'd1);
      chk("frozen_mm", mm_cnt1, 8'd1);
`ifdef HWT_MON_LOG_EN
      chk("fault_fv", first_vec1, 4'b1101);
`endif
      en = 1'b0;
      tick();
      chk("alarm_hold", state1, 2'b10);

      // clr during ALARM with a mismatch in flight
      send(4'b1101, 1'b0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      smp_vld = 1'b0;
      chk("clr_state", state1, 2'b00);
      chk("clr_mm", mm_cnt1, 8'd0);
      chk("clr_smp", smp_cnt1, 8'd0);
      chk("clr_alarm", alarm1, 1'b0);
`ifdef HWT_MON_LOG_EN
      chk("clr_fv", first_vec1, 4'b0000);
`endif
      en = 1'b1;
      tick();
      tick();
      chk("postclr_mm", mm_cnt1, 8'd0);
      chk("postclr_smp", smp_cnt1, 8'd0);
      chk("postclr_state", state1, 2'b01);

      // disarm after 5 of 10 samples, then re-arm for 3 more
      for (int i = 1; i <= 5; i++) send_ok(4'(i));
      smp_vld = 1'b0;
      en = 1'b0;
      tick();
      for (int i = 6; i <= 10; i++) send_ok(4'(i));
      smp_vld = 1'b0;
      tick();
      tick();
      chk("disarm_smp", smp_cnt1, 8'd5);
      chk("disarm_state", state1, 2'b00);
      en = 1'b1;
      tick();
      for (int i = 11; i <= 13; i++) send_ok(4'(i));
      smp_vld = 1'b0;
      tick();
      chk("rearm_smp", smp_cnt1, 8'd8);
      chk("rearm_mm", mm_cnt1, 8'd0);

      // saturation on the 4-bit instance
      en2 = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) send_ok(4'(i % 16));
      smp_vld = 1'b0;
      tick();
      chk("sat_smp", smp_cnt2, 4'd15);
      chk("sat_flag", smp_sat2, 1'b1);
      chk("sat_alarm", alarm2, 1'b0);
      chk("sat_mm", mm_cnt2, 4'd0);
      chk("sat_state", state2, 2'b01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
